// File: rtl/pcm_frame_packer_if.sv
// Frame-in / byte-out bus of pcm_frame_packer: PCM frame strobe, SPI byte request/response and buffer status.
// master = upstream/SPI side that drives frames and requests; slave = the packer.
interface pcm_frame_packer_if #(
  parameter int CHANNELS     = 2,
  parameter int SAMPLE_WIDTH = 24,
  parameter int DEPTH        = 1024,
  parameter int CNT_WIDTH    = 8
);
  localparam int LW = $clog2(DEPTH + 1);

  logic [CHANNELS*SAMPLE_WIDTH-1:0] pcm_data;
  logic                             pcm_valid;
  logic                             byte_req;
  logic [7:0]                       byte_out;
  logic                             byte_valid;
  logic [LW-1:0]                    level;
  logic                             empty;
  logic                             full;
  logic [CNT_WIDTH-1:0]             drop_count;
  logic [7:0]                       frame_seq;

  modport master (
    output pcm_data, pcm_valid, byte_req,
    input  byte_out, byte_valid, level, empty, full, drop_count, frame_seq
  );

  modport slave (
    input  pcm_data, pcm_valid, byte_req,
    output byte_out, byte_valid, level, empty, full, drop_count, frame_seq
  );
endinterface

// File: rtl/pcm_frame_packer.sv
// Packs multi-channel PCM frames into a byte ring buffer served one byte per SPI request.
// Optional macro FRAME_HEADER_EN prefixes each frame with sync byte 8'hA5 and the frame sequence number.
module pcm_frame_packer #(
  parameter int         CHANNELS     = 2,
  parameter int         SAMPLE_WIDTH = 24,
  parameter int         KEEP_BYTES   = 2,
  parameter int         DEPTH        = 1024,
  parameter logic [7:0] FILL_BYTE    = 8'h00,
  parameter int         CNT_WIDTH    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pcm_frame_packer_if.slave bus
);
  localparam int DW = CHANNELS * SAMPLE_WIDTH;
  localparam int PB = CHANNELS * KEEP_BYTES;
`ifdef FRAME_HEADER_EN
  localparam int HB = 2;
`else
  localparam int HB = 0;
`endif
  localparam int FB    = PB + HB;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int IW    = (FB > 1) ? $clog2(FB) : 1;
  localparam int SHIFT = SAMPLE_WIDTH - 8 * KEEP_BYTES;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t               state_r;
  logic [DW-1:0]        frame_r;
  logic [IW-1:0]        idx_r;
  logic [AW-1:0]        wptr_r;
  logic [AW-1:0]        rptr_r;
  logic [LW-1:0]        level_r;
  logic                 empty_r;
  logic                 full_r;
  logic [CNT_WIDTH-1:0] drop_r;
  logic [7:0]           seq_r;
  logic [7:0]           byte_out_r;
  logic                 byte_valid_r;
  logic [7:0]           mem_r [DEPTH];

  logic [8*PB-1:0]      payload_s;
  logic [7:0]           wr_byte_s;
  logic                 wr_en_s;
  logic                 rd_en_s;
  logic                 last_s;
  logic                 admit_s;
  logic [LW-1:0]        level_nxt_s;

  // Flatten the kept bytes of every channel into transmit order.
  always_comb begin
    payload_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < KEEP_BYTES; k++) begin
        payload_s[(c*KEEP_BYTES + k)*8 +: 8] = frame_r[c*SAMPLE_WIDTH + SHIFT + 8*k +: 8];
      end
    end
  end

  // Select the byte written in the current WRITE cycle.
  always_comb begin
    wr_byte_s = 8'h00;
`ifdef FRAME_HEADER_EN
    if (idx_r == IW'(0)) begin
      wr_byte_s = 8'hA5;
    end else if (idx_r == IW'(1)) begin
      wr_byte_s = seq_r;
    end else begin
      wr_byte_s = payload_s[8*int'(idx_r - IW'(2)) +: 8];
    end
`else
    wr_byte_s = payload_s[8*int'(idx_r) +: 8];
`endif
  end

  // Handshake decode and next fill level; admission reserves a whole frame of space up front.
  always_comb begin
    wr_en_s = (state_r == ST_WRITE);
    last_s  = wr_en_s && (idx_r == IW'(FB - 1));
    rd_en_s = bus.byte_req && (level_r != LW'(0));
    admit_s = bus.pcm_valid && (state_r == ST_IDLE) &&
              ((LW'(DEPTH) - level_r) >= LW'(FB));
    case ({wr_en_s, rd_en_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Byte storage without reset so it maps onto a simple dual-port RAM.
  always_ff @(posedge clk) begin
    if (wr_en_s && rst_n) begin
      mem_r[wptr_r] <= wr_byte_s;
    end
  end

  // Write FSM, read port, pointers and status counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      frame_r      <= '0;
      idx_r        <= '0;
      wptr_r       <= '0;
      rptr_r       <= '0;
      level_r      <= '0;
      empty_r      <= 1'b1;
      full_r       <= 1'b0;
      drop_r       <= '0;
      seq_r        <= 8'h00;
      byte_out_r   <= 8'h00;
      byte_valid_r <= 1'b0;
    end else begin
      level_r      <= level_nxt_s;
      empty_r      <= (level_nxt_s == LW'(0));
      full_r       <= (level_nxt_s == LW'(DEPTH));
      byte_valid_r <= bus.byte_req;
      if (bus.byte_req) begin
        byte_out_r <= rd_en_s ? mem_r[rptr_r] : FILL_BYTE;
      end
      if (rd_en_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      if (wr_en_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      // Frames arriving mid-write or without room are counted, never partially stored.
      if (bus.pcm_valid && !admit_s && (drop_r != '1)) begin
        drop_r <= drop_r + CNT_WIDTH'(1);
      end
      case (state_r)
        ST_IDLE: begin
          if (admit_s) begin
            frame_r <= bus.pcm_data;
            idx_r   <= '0;
            state_r <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (last_s) begin
            state_r <= ST_IDLE;
            seq_r   <= seq_r + 8'd1;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.byte_out   = byte_out_r;
  assign bus.byte_valid = byte_valid_r;
  assign bus.level      = level_r;
  assign bus.empty      = empty_r;
  assign bus.full       = full_r;
  assign bus.drop_count = drop_r;
  assign bus.frame_seq  = seq_r;

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Randomized bench for pcm_frame_packer against a queue-based byte-stream model (DEPTH=8, 4-bit drop counter).
// Honours FRAME_HEADER_EN when the bundle is compiled with it.
module tb_pcm_frame_packer;
  localparam int CH    = 2;
  localparam int SW    = 24;
  localparam int KB    = 2;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int DW    = CH * SW;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam logic [7:0] FILL = 8'h00;
`ifdef FRAME_HEADER_EN
  localparam int FB = CH * KB + 2;
`else
  localparam int FB = CH * KB;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcm_frame_packer_if #(.CHANNELS(CH), .SAMPLE_WIDTH(SW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

  pcm_frame_packer #(
    .CHANNELS(CH), .SAMPLE_WIDTH(SW), .KEEP_BYTES(KB), .DEPTH(DEPTH),
    .FILL_BYTE(FILL), .CNT_WIDTH(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: stored bytes, bytes still to be written, and counters.
  logic [7:0] stored  [$];
  logic [7:0] pending [$];
  logic [7:0] got     [$];
  logic [7:0] m_byte;
  logic       m_valid;
  int         m_drop;
  logic [7:0] m_seq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] kept_byte(input logic [DW-1:0] pd, input int c, input int k);
    logic [SW-1:0] s;
    s = SW'(pd >> (c * SW));
    return 8'(s >> (SW - 8 * KB + 8 * k));
  endfunction

  task automatic model_reset();
    stored.delete();
    pending.delete();
    m_byte  = 8'h00;
    m_valid = 1'b0;
    m_drop  = 0;
    m_seq   = 8'h00;
  endtask

  task automatic model_step(input logic pv, input logic [DW-1:0] pd, input logic req);
    int lvl0;
    bit busy;
    lvl0    = stored.size();
    busy    = (pending.size() > 0);
    m_valid = req;
    if (req) m_byte = (stored.size() > 0) ? stored.pop_front() : FILL;
    if (busy) begin
      stored.push_back(pending.pop_front());
      if (pending.size() == 0) m_seq = m_seq + 8'd1;
    end
    if (pv) begin
      if (!busy && (DEPTH - lvl0) >= FB) begin
`ifdef FRAME_HEADER_EN
        pending.push_back(8'hA5);
        pending.push_back(m_seq);
`endif
        for (int c = 0; c < CH; c++)
          for (int k = 0; k < KB; k++)
            pending.push_back(kept_byte(pd, c, k));
      end else if (m_drop < (1 << CW) - 1) begin
        m_drop++;
      end
    end
  endtask

  task automatic step(input logic pv, input logic [DW-1:0] pd, input logic req);
    bus.pcm_valid = pv;
    bus.pcm_data  = pd;
    bus.byte_req  = req;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(pv, pd, req);
    #1;
    chk("byte_valid", bus.byte_valid, m_valid);
    chk("byte_out", bus.byte_out, m_byte);
    chk("level", bus.level, stored.size());
    chk("empty", bus.empty, stored.size() == 0);
    chk("full", bus.full, stored.size() == DEPTH);
    chk("drop_count", bus.drop_count, m_drop);
    chk("frame_seq", bus.frame_seq, m_seq);
    if (bus.byte_valid) got.push_back(bus.byte_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  function automatic logic [DW-1:0] rnd_frame();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [7:0] t1_exp [$];
    int d0;
    int l0;
`ifdef FRAME_HEADER_EN
    t1_exp = '{8'hA5, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB};
`else
    t1_exp = '{8'h34, 8'h12, 8'hCD, 8'hAB};
`endif
    model_reset();
    bus.pcm_valid = 1'b0;
    bus.pcm_data  = '0;
    bus.byte_req  = 1'b0;

    // Reset state
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;

    // Read from an empty buffer returns the fill byte
    step(1'b0, '0, 1'b1);
    chk("t2_valid", bus.byte_valid, 1'b1);
    chk("t2_fill", bus.byte_out, 8'h00);
    chk("t2_empty", bus.empty, 1'b1);
    idle(1);
    chk("t2_pulse", bus.byte_valid, 1'b0);

    // Single frame, byte order check
    got.delete();
    step(1'b1, {24'hABCDEF, 24'h123456}, 1'b0);
    idle(FB);
    chk("t1_level", bus.level, FB);
    for (int i = 0; i < FB; i++) begin
      step(1'b0, '0, 1'b1);
      idle(1);
    end
    chk("t1_count", got.size(), FB);
    for (int i = 0; i < FB && i < got.size(); i++) chk("t1_byte", got[i], t1_exp[i]);
    chk("t1_seq", bus.frame_seq, 8'd1);

    // Fill the buffer: third frame has no room
    d0 = m_drop;
    for (int f = 0; f < 3; f++) begin
      step(1'b1, rnd_frame(), 1'b0);
      idle(FB + 1);
    end
`ifndef FRAME_HEADER_EN
    chk("t3_full", bus.full, 1'b1);
    chk("t3_level", bus.level, 8);
    chk("t3_drop", bus.drop_count, d0 + 1);
`endif
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1);

    // Frame strobe during the second write cycle is dropped
    d0 = m_drop;
    l0 = stored.size();
    step(1'b1, rnd_frame(), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, rnd_frame(), 1'b0);
    idle(FB);
    chk("t4_drop", bus.drop_count, d0 + 1);
    chk("t4_level", bus.level, l0 + FB);
    for (int i = 0; i < FB; i++) step(1'b0, '0, 1'b1);

    // Random interleaving of frames and reads; wraps pointers many times
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 4) == 0), rnd_frame(), ($urandom_range(0, 2) != 0));
    chk("sat_drop", bus.drop_count, 4'hF);

    // Reset in the middle of a frame write
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1);
    step(1'b1, rnd_frame(), 1'b0);
    step(1'b0, '0, 1'b0);
    rst_n = 1'b0;
    step(1'b0, '0, 1'b0);
    chk("rst_level", bus.level, 0);
    chk("rst_empty", bus.empty, 1'b1);
    rst_n = 1'b1;
    idle(FB + 1);
    step(1'b0, '0, 1'b1);
    chk("rst_fill", bus.byte_out, 8'h00);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
